// File: rtl/rv32_pkg.sv
// rv32_pkg
// Shared types and defaults for the rv32 instruction-fetch front end.
//   RESET_PC_DEFAULT : first fetch address after reset
//   fetch_entry_t    : one fetched instruction word together with its PC
package rv32_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/rv32_fetch_fifo.sv
// rv32_fetch_fifo
// Synchronous FIFO of fetch_entry_t used as the instruction queue.
// The head entry is read straight out of the storage registers.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   flush        : synchronous clear; overrides push and pop
//   push, push_data : write one entry at the tail
//   pop          : discard the head entry
//   head         : current head entry
//   empty, full  : occupancy flags
//   count        : number of stored entries (0..DEPTH)
module rv32_fetch_fifo
  import rv32_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       push,
  input  fetch_entry_t               push_data,
  input  logic                       pop,
  output fetch_entry_t               head,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  fetch_entry_t   storage [DEPTH];
  logic [PW-1:0]  rd_ptr;
  logic [PW-1:0]  wr_ptr;
  logic           do_push;
  logic           do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign head    = storage[rd_ptr];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Storage is cleared on reset so the head reads as zero while empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        storage[i] <= '0;
      end
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        storage[wr_ptr] <= push_data;
        wr_ptr          <= wr_ptr + PW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/rv32_fetch_unit.sv
// rv32_fetch_unit
// Instruction-fetch front end between decode and memory port A.
// Issues word addresses, tracks the fixed memory read latency with a
// shift register of {valid, pc}, queues returned words and hands them to
// decode over a valid/ready handshake. A redirect squashes everything in
// flight or queued and issues the new target in the same cycle.
// Ports:
//   clk_i, rst_n_i     : clock, asynchronous active-low reset
//   redirect_valid_i   : single-cycle redirect request
//   redirect_pc_i      : redirect target (bits [1:0] ignored)
//   mem_addr_o         : word address to memory port A
//   mem_instr_i        : memory port A read data
//   instr_valid_o      : queue head valid
//   instr_ready_i      : decode accepts the head
//   instr_o, instr_pc_o: head instruction word and its PC
module rv32_fetch_unit
  import rv32_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = RESET_PC_DEFAULT,
  parameter int          FIFO_DEPTH  = 4,
  parameter int          MEM_LATENCY = 2,
  parameter int          ADDR_WIDTH  = 14
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  redirect_valid_i,
  input  logic [31:0]           redirect_pc_i,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  input  logic [31:0]           mem_instr_i,
  output logic                  instr_valid_o,
  input  logic                  instr_ready_i,
  output logic [31:0]           instr_o,
  output logic [31:0]           instr_pc_o
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int SW = CW + 1;

  logic [31:0]            fetch_pc;
  logic [31:0]            addr_pc;
  logic [MEM_LATENCY-1:0] pipe_valid;
  logic [31:0]            pipe_pc [MEM_LATENCY];
  logic [CW-1:0]          inflight;
  logic [CW-1:0]          count;
  logic                   issue;
  logic                   push;
  logic                   pop;
  logic                   empty;
  logic                   full;
  fetch_entry_t           head;
  fetch_entry_t           push_data;

  // A redirect target bypasses the PC register so it reaches memory at once.
  assign addr_pc    = redirect_valid_i ? (redirect_pc_i & ~32'd3) : fetch_pc;
  assign mem_addr_o = addr_pc[ADDR_WIDTH+1:2];

  always_comb begin
    inflight = '0;
    for (int i = 0; i < MEM_LATENCY; i++) begin
      inflight = inflight + CW'(pipe_valid[i]);
    end
  end

  // Credits come from registered state only; a redirect empties both the
  // queue and the pipe, so the redirect target is always issued.
  assign issue = redirect_valid_i ||
                 (({1'b0, count} + {1'b0, inflight}) < SW'(FIFO_DEPTH));

  assign push      = pipe_valid[MEM_LATENCY-1] && !redirect_valid_i;
  assign pop       = instr_valid_o && instr_ready_i && !redirect_valid_i;
  assign push_data = '{instr: mem_instr_i, pc: pipe_pc[MEM_LATENCY-1]};

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      fetch_pc   <= RESET_PC;
      pipe_valid <= '0;
      for (int i = 0; i < MEM_LATENCY; i++) begin
        pipe_pc[i] <= '0;
      end
    end else begin
      fetch_pc      <= issue ? (addr_pc + 32'd4) : addr_pc;
      pipe_valid[0] <= issue;
      pipe_pc[0]    <= addr_pc;
      for (int i = 1; i < MEM_LATENCY; i++) begin
        pipe_valid[i] <= pipe_valid[i-1] && !redirect_valid_i;
        pipe_pc[i]    <= pipe_pc[i-1];
      end
    end
  end

  rv32_fetch_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk_i),
    .rst_n    (rst_n_i),
    .flush    (redirect_valid_i),
    .push     (push),
    .push_data(push_data),
    .pop      (pop),
    .head     (head),
    .empty    (empty),
    .full     (full),
    .count    (count)
  );

  assign instr_valid_o = !empty;
  assign instr_o       = head.instr;
  assign instr_pc_o    = head.pc;

  // The credit rule guarantees a returning word always finds a free slot.
  a_no_push_full: assert property (@(posedge clk_i) disable iff (!rst_n_i)
                                   !(push && full));

endmodule

// File: tb/tb_rv32_fetch_unit.sv
// tb_rv32_fetch_unit
// Self-checking bench for rv32_fetch_unit. A memory model returns
// 0xA0000000 | word_address two cycles after the address is presented.
// The reference model says: the accepted stream is the contiguous run of
// PCs starting at the most recent reset/redirect target.
module tb_rv32_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [13:0] mem_addr;
  logic [31:0] mem_instr;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;

  int tests = 0;
  int fails = 0;

  logic [31:0] expq [$];
  logic [31:0] model_next;
  int          gap;
  logic [13:0] addr_d1 = '0;
  logic [13:0] addr_d2 = '0;
  logic [13:0] hold_addr;

  rv32_fetch_unit #(
    .RESET_PC   (RESET_PC),
    .FIFO_DEPTH (4),
    .MEM_LATENCY(2),
    .ADDR_WIDTH (14)
  ) dut (
    .clk_i           (clk),
    .rst_n_i         (rst_n),
    .redirect_valid_i(redirect_valid),
    .redirect_pc_i   (redirect_pc),
    .mem_addr_o      (mem_addr),
    .mem_instr_i     (mem_instr),
    .instr_valid_o   (instr_valid),
    .instr_ready_i   (instr_ready),
    .instr_o         (instr),
    .instr_pc_o      (instr_pc)
  );

  always #5 clk = ~clk;

  // Two-cycle read latency memory model.
  always @(posedge clk) begin
    addr_d1 <= mem_addr;
    addr_d2 <= addr_d1;
  end
  assign mem_instr = 32'hA000_0000 | {18'd0, addr_d2};

  function automatic logic [31:0] modelInstr(input logic [31:0] pc);
    return 32'hA000_0000 | ((pc >> 2) & 32'h0000_3FFF);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %08h expected %08h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic refill();
    while (expq.size() < 8) begin
      expq.push_back(model_next);
      model_next = model_next + 32'd4;
    end
  endtask

  // Drives one cycle of inputs just after the rising edge.
  task automatic applyStimulus(input logic rdy, input logic redir,
                               input logic [31:0] tgt);
    @(posedge clk);
    #1;
    instr_ready    = rdy;
    redirect_valid = redir;
    redirect_pc    = tgt;
  endtask

  // Releases reset in cycle 0 and checks the first delivery in cycle 3.
  task automatic releaseReset();
    @(posedge clk);
    #1;
    rst_n          = 1'b1;
    instr_ready    = 1'b1;
    redirect_valid = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("startup_cycle2_valid", {31'd0, instr_valid}, 32'd0);
    @(negedge clk);
    checkOutput("startup_cycle3_valid", {31'd0, instr_valid}, 32'd1);
    checkOutput("startup_pc", instr_pc, RESET_PC);
    checkOutput("startup_instr", instr, 32'hA000_0000);
  endtask

  // Monitor and scoreboard: the expected PC stream is rebuilt on every
  // reset or redirect and consumed on every valid handshake.
  always @(negedge clk) begin
    if (!rst_n) begin
      expq.delete();
      model_next = RESET_PC;
      refill();
      gap = 0;
    end else if (redirect_valid) begin
      expq.delete();
      model_next = redirect_pc & ~32'd3;
      refill();
      gap = 0;
    end else begin
      if (instr_valid && instr_ready) begin
        if (expq.size() == 0) begin
          checkOutput("scoreboard_underflow", instr_pc, 32'hFFFF_FFFF);
        end else begin
          logic [31:0] exp_pc;
          exp_pc = expq.pop_front();
          checkOutput("stream_pc", instr_pc, exp_pc);
          checkOutput("stream_instr", instr, modelInstr(exp_pc));
          refill();
        end
      end
      if (instr_ready && !instr_valid) gap++;
      else gap = 0;
      if (gap > 4) begin
        checkOutput("liveness_gap", gap, 4);
        gap = 0;
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL timeout: got no finish expected finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    instr_ready    = 1'b1;
    #22;
    checkOutput("reset_valid", {31'd0, instr_valid}, 32'd0);
    checkOutput("reset_instr", instr, 32'd0);
    checkOutput("reset_pc", instr_pc, 32'd0);
    checkOutput("reset_addr", {18'd0, mem_addr}, RESET_PC >> 2);

    releaseReset();
    repeat (8) applyStimulus(1'b1, 1'b0, 32'd0);

    // Stall: once credits are exhausted the fetch address must hold.
    repeat (5) applyStimulus(1'b0, 1'b0, 32'd0);
    #1 hold_addr = mem_addr;
    repeat (5) begin
      applyStimulus(1'b0, 1'b0, 32'd0);
      #1;
      checkOutput("stall_addr_hold", {18'd0, mem_addr}, {18'd0, hold_addr});
      checkOutput("stall_valid", {31'd0, instr_valid}, 32'd1);
    end
    repeat (8) applyStimulus(1'b1, 1'b0, 32'd0);

    // Single redirect while streaming.
    applyStimulus(1'b1, 1'b1, 32'h0000_0100);
    #1 checkOutput("redirect_addr", {18'd0, mem_addr}, 32'h040);
    applyStimulus(1'b1, 1'b0, 32'd0);
    applyStimulus(1'b1, 1'b0, 32'd0);
    @(negedge clk);
    checkOutput("redirect_gap_valid", {31'd0, instr_valid}, 32'd0);
    applyStimulus(1'b1, 1'b0, 32'd0);
    @(negedge clk);
    checkOutput("redirect_first_valid", {31'd0, instr_valid}, 32'd1);
    checkOutput("redirect_first_pc", instr_pc, 32'h0000_0100);
    checkOutput("redirect_first_instr", instr, 32'hA000_0040);
    repeat (4) applyStimulus(1'b1, 1'b0, 32'd0);

    // Back-to-back redirects: the second target wins.
    applyStimulus(1'b1, 1'b1, 32'h0000_0200);
    applyStimulus(1'b1, 1'b1, 32'h0000_0300);
    repeat (3) applyStimulus(1'b1, 1'b0, 32'd0);
    @(negedge clk);
    checkOutput("b2b_first_pc", instr_pc, 32'h0000_0300);
    applyStimulus(1'b1, 1'b0, 32'd0);
    @(negedge clk);
    checkOutput("b2b_second_pc", instr_pc, 32'h0000_0304);
    repeat (4) applyStimulus(1'b1, 1'b0, 32'd0);

    // Word-address wrap while the full PC keeps counting.
    applyStimulus(1'b1, 1'b1, 32'h0000_FFFC);
    #1 checkOutput("wrap_addr0", {18'd0, mem_addr}, 32'h3FFF);
    applyStimulus(1'b1, 1'b0, 32'd0);
    #1 checkOutput("wrap_addr1", {18'd0, mem_addr}, 32'h0000);
    applyStimulus(1'b1, 1'b0, 32'd0);
    applyStimulus(1'b1, 1'b0, 32'd0);
    @(negedge clk);
    checkOutput("wrap_pc0", instr_pc, 32'h0000_FFFC);
    checkOutput("wrap_instr0", instr, 32'hA000_3FFF);
    applyStimulus(1'b1, 1'b0, 32'd0);
    @(negedge clk);
    checkOutput("wrap_pc1", instr_pc, 32'h0001_0000);
    checkOutput("wrap_instr1", instr, 32'hA000_0000);

    // Randomised ready and redirect traffic.
    for (int i = 0; i < 1500; i++) begin
      applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 39) == 0, $urandom);
    end

    // Fill the queue, then drop reset between clock edges.
    repeat (10) applyStimulus(1'b0, 1'b0, 32'd0);
    checkOutput("full_before_reset", {31'd0, instr_valid}, 32'd1);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    checkOutput("async_reset_valid", {31'd0, instr_valid}, 32'd0);
    checkOutput("async_reset_pc", instr_pc, 32'd0);
    repeat (2) @(posedge clk);
    releaseReset();
    repeat (10) applyStimulus(1'b1, 1'b0, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
